// File: rtl/cordic_output_buffer_if.sv
// Bundled result and stream signals of the CORDIC output stage.
// The master side is the CORDIC core plus the consumer. The slave side is the buffer.
interface cordic_output_buffer_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int FLIP_FLAG_WIDTH = 1,
  parameter int ADDR_WIDTH      = 2
);
  logic [DATA_WIDTH-1:0]      degree_out;
  logic [DATA_WIDTH-1:0]      x_out;
  logic [DATA_WIDTH-1:0]      y_out;
  logic [FLIP_FLAG_WIDTH-1:0] flip_out;
  logic                       arctan_en_out;
  logic                       valid_out;
  logic [2*DATA_WIDTH-1:0]    out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [ADDR_WIDTH:0]        fifo_count;
  logic                       overflow;
  logic                       overflow_clr;

  modport master (
    output degree_out, x_out, y_out, flip_out, arctan_en_out, valid_out,
    output out_ready, overflow_clr,
    input  out_data, out_valid, fifo_count, overflow
  );

  modport slave (
    input  degree_out, x_out, y_out, flip_out, arctan_en_out, valid_out,
    input  out_ready, overflow_clr,
    output out_data, out_valid, fifo_count, overflow
  );
endinterface

// File: rtl/cordic_output_buffer.sv
// CORDIC output stage: quadrant-flip correction with saturation, packing into bus words,
// and a first-word-fall-through FIFO with a sticky overflow flag.
module cordic_output_buffer #(
  parameter int DATA_WIDTH      = 16,
  parameter int FLIP_FLAG_WIDTH = 1,
  parameter int FIFO_DEPTH      = 4,
  parameter int ADDR_WIDTH      = 2
) (
  input logic                   clk,
  input logic                   rst,
  cordic_output_buffer_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MOST_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);

  // Two's-complement negate that clamps instead of wrapping at the most negative value.
  function automatic logic [DATA_WIDTH-1:0] sat_neg(input logic [DATA_WIDTH-1:0] v);
    return (v == MOST_NEG) ? MOST_POS : -v;
  endfunction

  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic [ADDR_WIDTH:0]     count;
  logic                    full;
  logic                    not_empty;
  logic                    push;
  logic                    pop;
  logic                    drop;
  logic                    flip_x;
  logic                    flip_y;
  logic [DATA_WIDTH-1:0]   x_c;
  logic [DATA_WIDTH-1:0]   y_c;
  logic [2*DATA_WIDTH-1:0] word;

  assign flip_x = bus.flip_out[0];

  if (FLIP_FLAG_WIDTH > 1) begin : g_flip_y
    assign flip_y = bus.flip_out[1];
  end else begin : g_no_flip_y
    assign flip_y = 1'b0;
  end

  always_comb begin
    x_c  = flip_x ? sat_neg(bus.x_out) : bus.x_out;
    y_c  = flip_y ? sat_neg(bus.y_out) : bus.y_out;
    word = bus.arctan_en_out ? {{DATA_WIDTH{1'b0}}, bus.degree_out} : {y_c, x_c};
  end

  assign full      = (count == DEPTH_CNT);
  assign not_empty = (count != '0);
  assign pop       = not_empty && bus.out_ready;
  // A pop on a full FIFO frees the slot the incoming word takes on the same edge.
  assign push      = bus.valid_out && (!full || pop);
  assign drop      = bus.valid_out && !push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      if (push && !pop)      count <= count + (ADDR_WIDTH+1)'(1);
      else if (pop && !push) count <= count - (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   bus.overflow <= 1'b0;
    else if (drop)             bus.overflow <= 1'b1;
    else if (bus.overflow_clr) bus.overflow <= 1'b0;
  end

  // Storage is not reset; stale entries are unreachable once the count is cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  assign bus.out_valid  = not_empty;
  assign bus.out_data   = not_empty ? mem[rd_ptr] : '0;
  assign bus.fifo_count = count;

endmodule

// File: doc/cordic_output_buffer.md
Name: cordic_output_buffer

Overview:
Parametrised output stage of the CORDIC core. It takes the raw per-cycle CORDIC results (angle, x, y, flip flags, arctan mode, valid), applies quadrant-flip correction with saturation, and packs each result into one bus word of 2*DATA_WIDTH bits. Packed words go into a first-word-fall-through FIFO drained by a valid/ready handshake. An overflow flag reports any result dropped while the FIFO is full. It sits between the last CORDIC iteration stage and the system bus / host interface.

Parameters:
DATA_WIDTH, 16, width of each CORDIC result field (degree, x, y); bus word is 2*DATA_WIDTH.
FLIP_FLAG_WIDTH, 1, width of flip flag; bit0 negates x, bit1 (if present) negates y, higher bits ignored.
FIFO_DEPTH, 4, number of FIFO entries; power of two, at least 2.
ADDR_WIDTH, 2, log2(FIFO_DEPTH).

Ports:
clk  input  1  core clock, all state on rising edge.
rst  input  1  asynchronous, active-high reset.
degree_out  input  DATA_WIDTH  signed angle result, arctan mode.
x_out  input  DATA_WIDTH  signed x result.
y_out  input  DATA_WIDTH  signed y result.
flip_out  input  FLIP_FLAG_WIDTH  quadrant-flip flags from the input stage.
arctan_en_out  input  1  1 = arctan (vectoring) result, 0 = rotation result.
valid_out  input  1  result present this cycle; no backpressure toward the core.
out_data  output  2*DATA_WIDTH  packed head-of-FIFO word.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts out_data this cycle.
fifo_count  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH.
overflow  output  1  sticky: at least one result dropped.
overflow_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, any time incl. mid-transfer): read/write pointers and count to 0; out_valid=0; out_data=0; fifo_count=0; overflow=0. FIFO contents discarded.
- Flip correction (combinational, before the FIFO): x_c = flip_out[0] ? -x_out : x_out; y_c = (FLIP_FLAG_WIDTH>1 && flip_out[1]) ? -y_out : y_out. Negating the most negative value (-2^(DATA_WIDTH-1)) saturates to 2^(DATA_WIDTH-1)-1. Never wraps.
- Packing: arctan_en_out=1 -> word = {DATA_WIDTH zeros, degree_out}; arctan_en_out=0 -> word = {y_c, x_c}. degree_out is never flipped.
- Write: push = valid_out && (!full || pop). The write happens on the clock edge; a word pushed at edge k makes out_valid high after edge k if the FIFO was empty (one-cycle latency, FWFT).
- Read: pop = out_valid && out_ready. The head advances at the edge. out_data always shows mem[rd_ptr] while out_valid=1 and is forced to 0 while out_valid=0. out_data/out_valid stay stable while out_valid && !out_ready.
- Full with simultaneous pop and push: both occur, count unchanged, no overflow.
- Full, valid_out=1, no pop: result dropped, overflow set at that edge.
- Empty with simultaneous push and pop: pop not possible (out_valid=0); push only.
- overflow_clr=1 clears overflow at the edge. If a drop happens on the same edge, set wins and overflow stays 1.
- fifo_count: +1 on push only, -1 on pop only, unchanged on both or neither. Pointers wrap modulo FIFO_DEPTH; full is count==FIFO_DEPTH.
- flip_out, arctan_en_out and the data inputs are don't-care when valid_out=0.

Test Plan:
- Rotation, flip=1: x_out=0x0100, y_out=0x0080, arctan_en=0, one valid pulse -> next cycle out_valid=1, out_data=0x0080FF00, fifo_count=1; out_ready=1 -> out_valid=0, out_data=0.
- Arctan mode: degree_out=0x1A2B, flip=1, x=0x7FFF -> out_data=0x00001A2B (no flip applied to degree, upper half zero).
- Saturation: flip=1, x_out=0x8000, y_out=0x0001 -> out_data=0x00017FFF.
- Fill and overflow (DEPTH=4, out_ready=0): 5 consecutive valids with x=1..5 -> fifo_count=4, overflow=1 after 5th edge; drain gives x=1,2,3,4 in order, 5 never appears. overflow_clr then clears the flag.
- Full with concurrent push/pop: FIFO full, out_ready=1 and valid_out=1 for 3 cycles -> fifo_count stays 4, overflow stays 0, output order preserved.
- Async reset mid-stream: 3 entries held, rst pulsed between clock edges -> out_valid, fifo_count, overflow and out_data go to 0 immediately without a clock; the next valid result appears as the only entry.
